// File: rtl/threshold_pkg.sv
// Shared widths, default frame geometry and FSM encoding for threshold_binarizer
// and its raster_counter sub-module.
package threshold_pkg;

  localparam int PIX_W     = 8;
  localparam int ADDR_W    = 7;
  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Saturating subtract: never wraps below zero.
  function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : {PIX_W{1'b0}};
  endfunction

endpackage

// File: rtl/threshold_binarizer_raster_counter.sv
// raster_counter: column/row raster counter with clear, enable, wrap and a
// last-pixel flag; also usable by the upstream capture stage.
module raster_counter
  import threshold_pkg::*;
#(
  parameter int W = IMG_W_DEF,
  parameter int H = IMG_H_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output logic              last
);

  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(W - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(H - 1);

  logic col_wrap;

  assign col_wrap = (col == COL_MAX);
  assign last     = col_wrap && (row == ROW_MAX);

  // Raster position; wraps to 0,0 after the last pixel of the frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + ADDR_W'(1);
      end else begin
        col <= col + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/threshold_binarizer.sv
// Raster-scan binarizer: addresses the threshold ROM, aligns pixels with the
// returned threshold and emits a 1-bit stream. Optional: THRESHOLD_OFFSET_EN.
module threshold_binarizer
  import threshold_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int ROM_LATENCY = 1
`ifdef THRESHOLD_OFFSET_EN
  ,
  parameter logic [PIX_W-1:0] OFFSET = 8'd0
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iStart,
  input  logic              iValid,
  input  logic [PIX_W-1:0]  iPixel,
  output logic [ADDR_W-1:0] oCol,
  output logic [ADDR_W-1:0] oRow,
  input  logic [PIX_W-1:0]  iThreshold,
  output logic              oValid,
  output logic              oBinary,
  output logic              oFrameDone,
  output logic              oBusy
);

  state_t                              state, state_next;
  logic                                cnt_clear;
  logic                                accept;
  logic                                last_pix;
  logic [ROM_LATENCY-1:0]              vld_pipe;
  logic [ROM_LATENCY-1:0][PIX_W-1:0]   pix_pipe;
  logic [PIX_W-1:0]                    thr_eff;

  assign accept = (state == ST_STREAM) && iValid;

  raster_counter #(.W(IMG_W), .H(IMG_H)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (accept),
    .col    (oCol),
    .row    (oRow),
    .last   (last_pix)
  );

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      oFrameDone <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      state      <= state_next;
      oFrameDone <= (state_next == ST_DONE);
      oBusy      <= (state_next != ST_IDLE);
    end
  end

  // Next-state logic; FLUSH waits only for the delay stages, not the output register.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iStart) begin
          state_next = ST_STREAM;
          cnt_clear  = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept && last_pix) state_next = ST_FLUSH;
        else                    state_next = ST_STREAM;
      end
      ST_FLUSH: begin
        if (vld_pipe == '0) state_next = ST_DONE;
        else                state_next = ST_FLUSH;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Delay pixels and their valid bits to meet the ROM's threshold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      pix_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      pix_pipe[0] <= iPixel;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pix_pipe[i] <= pix_pipe[i-1];
      end
    end
  end

  // Effective threshold for the compare stage.
  always_comb begin
`ifdef THRESHOLD_OFFSET_EN
    thr_eff = sat_sub(iThreshold, OFFSET);
`else
    thr_eff = iThreshold;
`endif
  end

  // Registered unsigned compare; binary forced low on bubbles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oValid  <= 1'b0;
      oBinary <= 1'b0;
    end else begin
      oValid  <= vld_pipe[ROM_LATENCY-1];
      oBinary <= vld_pipe[ROM_LATENCY-1] && (pix_pipe[ROM_LATENCY-1] > thr_eff);
    end
  end

endmodule

// File: doc/threshold_binarizer.md
Name: threshold_binarizer

Overview:
- Raster-scan binarization stage directly downstream of threshold_rom_reader.
- Accepts one 8-bit grayscale pixel per valid cycle for a 128x128 frame and drives the column/row address into the ROM reader.
- Aligns each pixel with the threshold the ROM returns, compares them, and emits a 1-bit binary pixel stream with frame-done signalling to the display/output stage.

Parameters:
- IMG_W, 128, pixels per row; power of two, max 128.
- IMG_H, 128, rows per frame; power of two, max 128.
- ROM_LATENCY, 1, clock cycles from oCol/oRow to a valid iThreshold.
- OFFSET, 8'd0, constant subtracted from the threshold. Used only with THRESHOLD_OFFSET_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle pulse that begins a frame. Ignored unless in IDLE.
- iValid  in  1  iPixel is valid this cycle.
- iPixel  in  8  grayscale pixel, raster order.
- oCol  out  7  column address to threshold_rom_reader.iCol.
- oRow  out  7  row address to threshold_rom_reader.iRow.
- iThreshold  in  8  threshold_rom_reader.oData.
- oValid  out  1  oBinary is valid.
- oBinary  out  1  1 = pixel above threshold (white).
- oFrameDone  out  1  one-cycle pulse after the last output pixel.
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - FSM returns to IDLE.
  - Counters and all pipeline valid bits clear.
  - oCol, oRow, oValid, oBinary, oFrameDone and oBusy all go to 0.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE -> STREAM on iStart. Counters are zeroed.
  - STREAM: each cycle with iValid high accepts one pixel.
    - oCol and oRow are registered counter outputs, so the address presented in cycle N belongs to the pixel accepted in cycle N.
    - The column increments after each accepted pixel. It wraps IMG_W-1 -> 0 and increments the row.
    - On acceptance of pixel (IMG_W-1, IMG_H-1), the FSM moves to FLUSH. Counters wrap to 0,0.
    - Cycles with iValid low leave the counters unchanged and insert a bubble, which propagates as oValid=0.
  - FLUSH: iValid is ignored. The FSM waits until the pipeline valid bits are all clear, then goes to DONE.
  - DONE: lasts one cycle, with oFrameDone=1, then returns to IDLE.
- Pipeline:
  - iPixel and its valid bit are delayed ROM_LATENCY stages so they meet iThreshold.
  - Compare result is registered. Pixel-in to oValid/oBinary latency is exactly ROM_LATENCY+1 cycles (2 by default).
  - Compare is unsigned: oBinary = (pixel > threshold). Equal values give 0.
  - oBinary is held at 0 whenever oValid=0.
- Boundary conditions:
  - iStart in any state other than IDLE is ignored. A frame in flight is never restarted.
  - iValid in IDLE, FLUSH or DONE is dropped.
  - Back-to-back frames: iStart may be asserted in the cycle after DONE.

Optional Feature:
- THRESHOLD_OFFSET_EN defined:
  - Effective threshold = iThreshold - OFFSET, saturating at 0 (no wrap).
  - The subtraction sits in the compare stage. Latency is unchanged.
- THRESHOLD_OFFSET_EN undefined:
  - iThreshold is used directly.
  - OFFSET is unused and synthesizes no logic.

Decomposition:
- Shared package threshold_pkg:
  - FSM state encoding (IDLE=0, STREAM=1, FLUSH=2, DONE=3).
  - Pixel width (8) and address width (7).
  - Default IMG_W/IMG_H.
- One sub-module: raster_counter. Parameterized col/row counter with enable, clear, wrap and last-pixel flag. It is reusable by the upstream capture stage.

Test Plan:
- Reset mid-STREAM at pixel (5,3) -> all outputs 0 immediately. The next iStart restarts addresses at 0,0.
- iStart, then 16384 consecutive valid pixels of value 0x80, with the ROM model returning 0x7F everywhere:
  - oCol/oRow step 0..127 with row wrap.
  - oBinary=1 for every pixel, each arriving 2 cycles after its input.
  - oFrameDone pulses once, 3 cycles after the last pixel.
- Pixel equal to threshold (0x40 vs 0x40) -> oBinary=0. Pixel 0x41 -> 1. Pixel 0x3F -> 0.
- iValid toggling 1,0,1,0 -> addresses advance only on valid cycles. oValid shows the same gap pattern, delayed by 2 cycles.
- iStart pulsed during STREAM, and iValid held high during FLUSH -> no counter change, no extra outputs. Exactly 16384 oValid pulses per frame.
- THRESHOLD_OFFSET_EN with OFFSET=8'd16:
  - threshold 0x08 -> effective 0x00, so pixel 0x01 gives oBinary=1.
  - threshold 0x50 -> effective 0x40, so pixel 0x41 gives 1 and pixel 0x40 gives 0.
